// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO_8 read-side controller slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents:
//   FIFO_WIDTH / FIFO_DEPTH  geometry of the upstream FIFO_8
//   OCC_W                    width of the mirrored occupancy (0..FIFO_DEPTH)
//   SKID_DEPTH / SKID_CNT_W  geometry of the 2-entry output skid buffer
//   occ_op_e / occ_op()      per-cycle occupancy update decision
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int OCC_W      = 4;
  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = 2;

  // Net effect of one cycle of FIFO activity on the occupancy mirror.
  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,
    OCC_INC  = 2'd1,
    OCC_DEC  = 2'd2
  } occ_op_e;

  // A write while full is rejected by FIFO_8 even if a read happens in the
  // same cycle, so a full FIFO with read+write still drops by one.
  // The empty guard keeps the mirror from wrapping below zero.
  function automatic occ_op_e occ_op(input logic wen, input logic ren,
                                     input logic full, input logic empty);
    occ_op_e op;
    op = OCC_HOLD;
    if (ren && !empty) begin
      op = (wen && !full) ? OCC_HOLD : OCC_DEC;
    end else if (wen && !full) begin
      op = OCC_INC;
    end
    return op;
  endfunction

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// Handshake bundle between FIFO_8, the drain controller and the byte stream.
// Latency: n/a (wires only).
// Backpressure: m_ready from the stream consumer; the FIFO side has none.
// Signals:
//   fifo_wen    copy of the write strobe going into FIFO_8
//   fifo_ren    read strobe into FIFO_8
//   fifo_dout   FIFO_8 registered read data
//   fifo_error  FIFO_8 error flag
//   m_data / m_valid / m_ready   outgoing valid/ready byte stream
// Modports: master = controller view, slave = FIFO + stream consumer view.
interface fifo_drain_ctrl_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) ();

  logic             fifo_wen;
  logic             fifo_ren;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_error;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    input  fifo_wen,
    input  fifo_dout,
    input  fifo_error,
    input  m_ready,
    output fifo_ren,
    output m_data,
    output m_valid
  );

  modport slave (
    output fifo_wen,
    output fifo_dout,
    output fifo_error,
    output m_ready,
    input  fifo_ren,
    input  m_data,
    input  m_valid
  );

endinterface

// File: rtl/skid_buf2.sv
// Two-entry register queue holding bytes read out of FIFO_8.
// Latency: push visible at head one cycle later (registered).
// Backpressure: none internally; caller only pushes when a slot is free.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push, din  write din at the tail
//   pop        remove the head (ignored when empty)
//   head       oldest entry; slot 0 is always the head
//   cnt        number of valid entries, 0..SKID_DEPTH
//   vld        head holds valid data
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [SKID_CNT_W-1:0] cnt,
  output logic                  vld
);

  localparam logic [SKID_CNT_W-1:0] CNT_FULL = SKID_CNT_W'(SKID_DEPTH);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (cnt != '0);
  // A push into a full queue is only legal if the head leaves that cycle.
  assign push_ok = push && ((cnt != CNT_FULL) || pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == '0) begin
            slot0 <= din;
          end else begin
            slot1 <= din;
          end
          cnt <= cnt + 1'b1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 1'b1;
        end
        2'b11: begin
          // Count is unchanged; the new byte lands behind whatever remains.
          if (cnt == 2'(1)) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head = slot0;
  assign vld  = (cnt != '0);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains FIFO_8 into a valid/ready byte stream through a 2-entry skid buffer.
// Latency: write at edge N -> fifo_ren in cycle N+1 -> m_valid/m_data at edge N+2.
// Backpressure: m_ready low stops reads once buffered + in-flight bytes reach 2.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   bus          fifo_drain_ctrl_if.master (FIFO strobes/data, output stream)
//   occupancy    mirrored FIFO_8 fill level, 0..DEPTH
//   byte_cnt     bytes delivered (m_valid & m_ready), wraps at 2^CNT_W
//   err_sticky   FIFO error, write-while-full, or sequence error; cleared by rst
//   seq_err      only with SEQ_CHECK_EN: one-cycle pulse after a popped byte
//                that is not previous popped byte + 1 (mod 2^WIDTH)
// Build option: define SEQ_CHECK_EN to add the seq_err port and its checker.
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  fifo_drain_ctrl_if.master   bus,
  output logic [OCC_W-1:0]    occupancy,
  output logic [CNT_W-1:0]    byte_cnt,
  output logic                err_sticky
`ifdef SEQ_CHECK_EN
  ,
  output logic                seq_err
`endif
);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [2:0]       SKID_LIM = 3'(SKID_DEPTH);

  logic                  inflight;
  logic [SKID_CNT_W-1:0] buf_cnt;
  logic                  pop;
  logic                  occ_full;
  logic                  occ_empty;
  logic [2:0]            credit_use;
  logic                  seq_mis;

  assign pop       = bus.m_valid && bus.m_ready;
  assign occ_full  = (occupancy == OCC_FULL);
  assign occ_empty = (occupancy == '0);

  // Slots that will be taken after this edge if no new read is issued:
  // what is buffered, plus the byte landing from last cycle's read, minus
  // the byte leaving now. A read is only issued if that leaves a free slot,
  // so the skid buffer can never overflow.
  assign credit_use = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};

  // Gating with rst keeps the strobe quiet while FIFO_8 is being reset
  // alongside this block.
  assign bus.fifo_ren = !rst && !occ_empty && (credit_use < SKID_LIM);

  skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (bus.fifo_dout),
    .pop  (pop),
    .head (bus.m_data),
    .cnt  (buf_cnt),
    .vld  (bus.m_valid)
  );

  // fifo_dout updates on the edge that samples fifo_ren, so the data is
  // captured one cycle after the strobe. Reset drops a pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= bus.fifo_ren;
    end
  end

  // Occupancy mirror, tracking FIFO_8 from the observed write strobe and our
  // own read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      case (occ_op(bus.fifo_wen, bus.fifo_ren, occ_full, occ_empty))
        OCC_INC: occupancy <= occupancy + 1'b1;
        OCC_DEC: occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
    end else if (pop) begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (bus.fifo_error || (bus.fifo_wen && occ_full) || seq_mis) begin
      err_sticky <= 1'b1;
    end
  end

`ifdef SEQ_CHECK_EN
  logic [WIDTH-1:0] last_byte;
  logic             have_last;

  // The first pop after reset has nothing to compare against.
  assign seq_mis = pop && have_last && (bus.m_data != WIDTH'(last_byte + 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_byte <= '0;
      have_last <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      seq_err <= seq_mis;
      if (pop) begin
        last_byte <= bus.m_data;
        have_last <= 1'b1;
      end
    end
  end
`else
  assign seq_mis = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl with a behavioural FIFO_8 and a stream scoreboard.
// Latency: n/a (testbench).
// Backpressure: m_ready driven by the scenarios (fixed, toggling, random).
module tb_fifo_drain_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wdata;
  logic [3:0]  occupancy;
  logic [15:0] byte_cnt;
  logic        err_sticky;
`ifdef SEQ_CHECK_EN
  logic        seq_err;
`endif

  fifo_drain_ctrl_if #(.WIDTH(8)) bus ();

  fifo_drain_ctrl #(
    .WIDTH (8),
    .DEPTH (8),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .occupancy  (occupancy),
    .byte_cnt   (byte_cnt),
    .err_sticky (err_sticky)
`ifdef SEQ_CHECK_EN
    ,
    .seq_err    (seq_err)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: FIFO_8 contents, bytes it accepted, bytes popped.
  logic [7:0] fq[$];
  logic [7:0] acc[$];
  logic [7:0] rx[$];
  logic       s_wen = 1'b0, s_ren = 1'b0, s_pop = 1'b0;
  logic [7:0] s_din = 8'h00, s_data = 8'h00;
  logic       exp_err = 1'b0;
  int         exp_bytes = 0;
  int         uflow_seen = 0;
  logic       exp_seq = 1'b0;
  logic       have_last = 1'b0;
  logic [7:0] last_byte = 8'h00;

  // Inputs change just after posedge, so mid-cycle values are what the
  // next rising edge will see.
  always @(negedge clk) begin
    s_wen  = bus.fifo_wen;
    s_ren  = bus.fifo_ren;
    s_din  = wdata;
    s_pop  = bus.m_valid && bus.m_ready;
    s_data = bus.m_data;
  end

  always @(posedge clk) begin : model
    int sz;
    if (rst) begin
      fq.delete();
      acc.delete();
      rx.delete();
      bus.fifo_dout  <= 8'h00;
      bus.fifo_error <= 1'b0;
      exp_err   = 1'b0;
      exp_bytes = 0;
      exp_seq   = 1'b0;
      have_last = 1'b0;
      last_byte = 8'h00;
    end else begin
      sz = fq.size();
      if ((s_wen && sz == 8) || bus.fifo_error) exp_err = 1'b1;
      bus.fifo_error <= (s_wen && sz == 8) || (s_ren && sz == 0);
      if (s_ren && sz == 0) uflow_seen++;
      if (s_ren && sz > 0) bus.fifo_dout <= fq.pop_front();
      if (s_wen && sz < 8) begin
        fq.push_back(s_din);
        acc.push_back(s_din);
      end
      exp_seq = 1'b0;
      if (s_pop) begin
        if (have_last && s_data != 8'(last_byte + 1)) exp_seq = 1'b1;
        last_byte = s_data;
        have_last = 1'b1;
        rx.push_back(s_data);
        exp_bytes++;
      end
`ifdef SEQ_CHECK_EN
      if (exp_seq) exp_err = 1'b1;
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.fifo_wen = 1'b0;
    bus.m_ready  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (bus.fifo_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %b want 0", bus.fifo_ren); end
      n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.m_valid); end
      n_checks++; if (bus.m_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.m_data); end
      n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
      n_checks++; if (byte_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", byte_cnt); end
      n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_sticky); end
      tick();
    end
  endtask

  // Two writes in cycles 0 and 1: read strobe in cycle 1, bytes on the
  // stream in cycles 3 and 4.
  task automatic test_basic();
    do_reset();
    bus.m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.fifo_wen = (c < 2);
      wdata = (c == 0) ? 8'h01 : 8'h02;
      @(negedge clk);
      n_checks++; if (bus.fifo_error !== 1'b0) begin n_fail++; $display("FAIL basic_fifo_error c%0d: got %b want 0", c, bus.fifo_error); end
      if (c == 1) begin
        n_checks++; if (bus.fifo_ren !== 1'b1) begin n_fail++; $display("FAIL basic_ren_latency: got %b want 1", bus.fifo_ren); end
      end
      if (c == 3) begin
        n_checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h01) begin n_fail++; $display("FAIL basic_first: got v%b d%h want v1 d01", bus.m_valid, bus.m_data); end
      end
      if (c == 4) begin
        n_checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h02) begin n_fail++; $display("FAIL basic_second: got v%b d%h want v1 d02", bus.m_valid, bus.m_data); end
      end
      if (c == 5) begin
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b want 0", bus.m_valid); end
      end
      tick();
    end
    @(negedge clk);
    n_checks++; if (byte_cnt !== 16'd2) begin n_fail++; $display("FAIL basic_cnt: got %0d want 2", byte_cnt); end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL basic_occ: got %0d want 0", occupancy); end
    tick();
  endtask

  // With the stream stalled, two bytes move into the skid buffer before reads
  // stop, so the FIFO only saturates after ten writes (0x03..0x0C); the
  // eleventh (0x0D) is the rejected one.
  task automatic test_fill_drain();
    logic [7:0] e;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      bus.fifo_wen = (c <= 10);
      wdata = 8'(8'h03 + c);
      @(negedge clk);
      if (c >= 3) begin
        n_checks++; if (bus.fifo_ren !== 1'b0) begin n_fail++; $display("FAIL fill_ren c%0d: got %b want 0", c, bus.fifo_ren); end
      end
      if (c == 10) begin
        n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL fill_occ_full: got %0d want 8", occupancy); end
        n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL fill_err_early: got %b want 0", err_sticky); end
      end
      if (c == 11) begin
        n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL fill_occ_sat: got %0d want 8", occupancy); end
        n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL fill_err_set: got %b want 1", err_sticky); end
      end
      if (c == 12) begin
        n_checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h03) begin n_fail++; $display("FAIL fill_skid_head: got v%b d%h want v1 d03", bus.m_valid, bus.m_data); end
      end
      tick();
    end
    bus.m_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      e = 8'(8'h03 + k);
      if (k < 10) begin
        n_checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== e) begin n_fail++; $display("FAIL drain_k%0d: got v%b d%h want v1 d%h", k, bus.m_valid, bus.m_data, e); end
      end else begin
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL drain_end_k%0d: got %b want 0", k, bus.m_valid); end
      end
      tick();
    end
    @(negedge clk);
    n_checks++; if (byte_cnt !== 16'd10) begin n_fail++; $display("FAIL drain_cnt: got %0d want 10", byte_cnt); end
    n_checks++; if (rx.size() != 10) begin n_fail++; $display("FAIL drain_rx_size: got %0d want 10", rx.size()); end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL drain_occ: got %0d want 0", occupancy); end
    tick();
  endtask

  task automatic test_toggle();
    logic       held;
    logic [7:0] held_dat;
    logic [7:0] e;
    do_reset();
    held = 1'b0;
    held_dat = 8'h00;
    for (int c = 0; c < 40; c++) begin
      bus.fifo_wen = (c < 6);
      wdata = 8'(8'h20 + c);
      bus.m_ready = c[0];
      @(negedge clk);
      if (held) begin
        n_checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== held_dat) begin n_fail++; $display("FAIL toggle_stable c%0d: got v%b d%h want v1 d%h", c, bus.m_valid, bus.m_data, held_dat); end
      end
      held = bus.m_valid && !bus.m_ready;
      held_dat = bus.m_data;
      tick();
    end
    @(negedge clk);
    n_checks++; if (rx.size() != 6) begin n_fail++; $display("FAIL toggle_count: got %0d want 6", rx.size()); end
    for (int k = 0; k < 6 && k < rx.size(); k++) begin
      e = 8'(8'h20 + k);
      n_checks++; if (rx[k] !== e) begin n_fail++; $display("FAIL toggle_order k%0d: got %h want %h", k, rx[k], e); end
    end
    n_checks++; if (byte_cnt !== 16'd6) begin n_fail++; $display("FAIL toggle_cnt: got %0d want 6", byte_cnt); end
    tick();
  endtask

`ifdef SEQ_CHECK_EN
  // Pops of 0x10, 0x11, 0x13 land in cycles 3..5; only the 0x13 pop is out
  // of sequence, so seq_err is high in cycle 6 alone.
  task automatic test_seq();
    int pulses;
    int pulse_c;
    do_reset();
    bus.m_ready = 1'b1;
    pulses = 0;
    pulse_c = -1;
    for (int c = 0; c < 10; c++) begin
      bus.fifo_wen = (c < 3);
      wdata = (c == 0) ? 8'h10 : (c == 1) ? 8'h11 : 8'h13;
      @(negedge clk);
      n_checks++; if (seq_err !== exp_seq) begin n_fail++; $display("FAIL seq_model c%0d: got %b want %b", c, seq_err, exp_seq); end
      if (seq_err === 1'b1) begin
        pulses++;
        pulse_c = c;
      end
      tick();
    end
    @(negedge clk);
    n_checks++; if (pulses != 1 || pulse_c != 6) begin n_fail++; $display("FAIL seq_pulse: got %0d pulses at c%0d want 1 at c6", pulses, pulse_c); end
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL seq_sticky: got %b want 1", err_sticky); end
    tick();
  endtask
`endif

  // Reset lands while a read is in flight and bytes are buffered.
  task automatic test_rst_mid();
    do_reset();
    bus.m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.fifo_wen = (c < 3);
      wdata = 8'(8'h40 + c);
      rst = (c == 4);
      @(negedge clk);
      if (c == 4) begin
        n_checks++; if (byte_cnt !== 16'd1) begin n_fail++; $display("FAIL rstmid_pre_cnt: got %0d want 1", byte_cnt); end
      end
      if (c == 5) begin
        n_checks++; if (bus.fifo_ren !== 1'b0) begin n_fail++; $display("FAIL rstmid_ren: got %b want 0", bus.fifo_ren); end
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", bus.m_valid); end
        n_checks++; if (bus.m_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h want 00", bus.m_data); end
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL rstmid_occ: got %0d want 0", occupancy); end
        n_checks++; if (byte_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", byte_cnt); end
        n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b want 0", err_sticky); end
      end
      tick();
    end
    for (int c = 0; c < 10; c++) begin
      bus.fifo_wen = (c < 2);
      wdata = 8'(8'h50 + c);
      tick();
    end
    @(negedge clk);
    n_checks++; if (rx.size() != 2) begin n_fail++; $display("FAIL rstmid_post_count: got %0d want 2", rx.size()); end
    if (rx.size() == 2) begin
      n_checks++; if (rx[0] !== 8'h50 || rx[1] !== 8'h51) begin n_fail++; $display("FAIL rstmid_post_data: got %h %h want 50 51", rx[0], rx[1]); end
    end
    n_checks++; if (byte_cnt !== 16'd2) begin n_fail++; $display("FAIL rstmid_post_cnt: got %0d want 2", byte_cnt); end
    tick();
  endtask

  // First phase starves the consumer to force saturation and rejected writes,
  // second phase runs mostly open.
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.fifo_wen = ($urandom_range(99) < 40);
      wdata = 8'($urandom);
      bus.m_ready = ($urandom_range(99) < ((i < 500) ? 20 : 75));
      @(negedge clk);
      n_checks++; if (int'(occupancy) != fq.size()) begin n_fail++; $display("FAIL rand_occ i%0d: got %0d want %0d", i, occupancy, fq.size()); end
      n_checks++; if (byte_cnt !== 16'(exp_bytes)) begin n_fail++; $display("FAIL rand_cnt i%0d: got %0d want %0d", i, byte_cnt, exp_bytes); end
      n_checks++; if (err_sticky !== exp_err) begin n_fail++; $display("FAIL rand_err i%0d: got %b want %b", i, err_sticky, exp_err); end
      if (bus.m_valid === 1'b1) begin
        n_checks++;
        if (rx.size() >= acc.size()) begin
          n_fail++; $display("FAIL rand_extra i%0d: got d%h with no byte pending", i, bus.m_data);
        end else if (bus.m_data !== acc[rx.size()]) begin
          n_fail++; $display("FAIL rand_order i%0d: got %h want %h", i, bus.m_data, acc[rx.size()]);
        end
      end
      tick();
    end
    bus.fifo_wen = 1'b0;
    bus.m_ready  = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    @(negedge clk);
    n_checks++; if (rx.size() != acc.size()) begin n_fail++; $display("FAIL rand_drained: got %0d bytes want %0d", rx.size(), acc.size()); end
    n_checks++; if (uflow_seen != 0) begin n_fail++; $display("FAIL rand_underflow: got %0d reads of empty FIFO want 0", uflow_seen); end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL rand_final_occ: got %0d want 0", occupancy); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.fifo_wen = 1'b0;
    bus.m_ready  = 1'b0;
    wdata = 8'h00;
    test_reset();
    test_basic();
    test_fill_drain();
    test_toggle();
`ifdef SEQ_CHECK_EN
    test_seq();
`endif
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
